// File: rtl/uart_pkg.sv
// Shared types and defaults for the UART receive path.
// RX_FIFO_ERR_TAG_EN (macro) selects whether buffered entries carry the receiver error tag.
package uart_pkg;

    localparam int UART_DATA_BITS  = 8;
    localparam int UART_FIFO_DEPTH = 8;

    // Bit order matches Rx_Error: [2] frame, [1] parity, [0] break
    typedef struct packed {
        logic frame;
        logic parity;
        logic brk;
    } rx_err_t;

    localparam logic [2:0] RX_ERR_NONE = 3'b000;

endpackage

// File: rtl/uart_fifo_ram.sv
// Storage array for the receive FIFO: one synchronous write port, one asynchronous read port.
// Contents are deliberately not reset.
module uart_fifo_ram #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/uart_rx_fifo.sv
// Receive buffer between the UART receiver and the host read side, with RTS flow control.
// Define RX_FIFO_ERR_TAG_EN to store and return the 3-bit receiver error tag per byte.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int DATA_BITS   = UART_DATA_BITS,
    parameter int FIFO_DEPTH  = UART_FIFO_DEPTH,
    parameter int FULL_THRESH = FIFO_DEPTH / 2
) (
    input  logic                 SysClk,
    input  logic                 Rst,
    input  logic [DATA_BITS-1:0] Data_In,
    input  logic                 Data_Rdy,
    input  logic [2:0]           Rx_Error,
    input  logic                 Read_Done,
    output logic [DATA_BITS-1:0] Data_Out,
    output logic [2:0]           Err_Out,
    output logic                 FIFO_Empty,
    output logic                 FIFO_Full,
    output logic                 FIFO_Overflow,
    output logic                 RTS
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
`ifdef RX_FIFO_ERR_TAG_EN
    localparam int W = DATA_BITS + 3;
`else
    localparam int W = DATA_BITS;
`endif

    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count;
    logic          tag_ok, at_depth, rd_en, wr_en, ovf_set;
    logic [W-1:0]  wdata, rdata;

`ifdef RX_FIFO_ERR_TAG_EN
    rx_err_t err_in;
    assign err_in = rx_err_t'(Rx_Error);
    assign tag_ok = 1'b1;
    assign wdata  = {err_in, Data_In};
`else
    // Errored bytes are dropped at the door, so they never count toward overflow
    assign tag_ok = (Rx_Error == RX_ERR_NONE);
    assign wdata  = Data_In;
`endif

    assign at_depth = (count == CW'(FIFO_DEPTH));
    assign rd_en    = Read_Done && (count != '0);
    // A pop in the same cycle frees the slot the write needs when full
    assign wr_en    = Data_Rdy && tag_ok && (!at_depth || rd_en);
    assign ovf_set  = Data_Rdy && tag_ok && at_depth && !Read_Done;

    uart_fifo_ram #(
        .WIDTH (W),
        .DEPTH (FIFO_DEPTH),
        .AW    (AW)
    ) u_ram (
        .clk   (SysClk),
        .we    (wr_en),
        .waddr (wr_ptr),
        .wdata (wdata),
        .raddr (rd_ptr),
        .rdata (rdata)
    );

    always_ff @(posedge SysClk or negedge Rst) begin
        if (!Rst) begin
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            count         <= '0;
            FIFO_Overflow <= 1'b0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            if (rd_en) rd_ptr <= rd_ptr + 1'b1;
            count <= count + CW'(wr_en) - CW'(rd_en);
            if (ovf_set) FIFO_Overflow <= 1'b1;
        end
    end

    always_ff @(posedge SysClk or negedge Rst) begin
        if (!Rst) begin
            Data_Out <= '0;
        end else if (rd_en) begin
            Data_Out <= rdata[DATA_BITS-1:0];
        end
    end

`ifdef RX_FIFO_ERR_TAG_EN
    always_ff @(posedge SysClk or negedge Rst) begin
        if (!Rst) begin
            Err_Out <= RX_ERR_NONE;
        end else if (rd_en) begin
            Err_Out <= rdata[W-1 -: 3];
        end
    end
`else
    assign Err_Out = RX_ERR_NONE;
`endif

    assign FIFO_Empty = (count == '0);
    assign FIFO_Full  = (count >= CW'(FULL_THRESH));
    assign RTS        = ~FIFO_Full;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Scoreboard bench for uart_rx_fifo: reads push expected words, a monitor checks each pop.
module tb_uart_rx_fifo;

    logic       SysClk = 1'b0;
    logic       Rst    = 1'b0;
    logic [7:0] Data_In = '0;
    logic       Data_Rdy = 1'b0;
    logic [2:0] Rx_Error = '0;
    logic       Read_Done = 1'b0;
    logic [7:0] Data_Out;
    logic [2:0] Err_Out;
    logic       FIFO_Empty, FIFO_Full, FIFO_Overflow, RTS;

    int total  = 0;
    int passed = 0;
    logic [10:0] exp_q [$];

    uart_rx_fifo #(.DATA_BITS(8), .FIFO_DEPTH(8), .FULL_THRESH(4)) dut (
        .SysClk        (SysClk),
        .Rst           (Rst),
        .Data_In       (Data_In),
        .Data_Rdy      (Data_Rdy),
        .Rx_Error      (Rx_Error),
        .Read_Done     (Read_Done),
        .Data_Out      (Data_Out),
        .Err_Out       (Err_Out),
        .FIFO_Empty    (FIFO_Empty),
        .FIFO_Full     (FIFO_Full),
        .FIFO_Overflow (FIFO_Overflow),
        .RTS           (RTS)
    );

    always #5 SysClk = ~SysClk;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic chk_flags(input string name, input logic e, input logic f, input logic o);
        chk({name, ".empty"}, 16'(FIFO_Empty), 16'(e));
        chk({name, ".full"},  16'(FIFO_Full),  16'(f));
        chk({name, ".rts"},   16'(RTS),        16'(!f));
        chk({name, ".ovf"},   16'(FIFO_Overflow), 16'(o));
    endtask

    task automatic wr(input logic [7:0] d, input logic [2:0] e);
        @(negedge SysClk);
        Data_In = d; Rx_Error = e; Data_Rdy = 1'b1;
        @(negedge SysClk);
        Data_Rdy = 1'b0; Rx_Error = '0;
    endtask

    // push: whether the read is expected to pop a word (FIFO not empty)
    task automatic rd(input logic push, input logic [7:0] d, input logic [2:0] e);
        @(negedge SysClk);
        Read_Done = 1'b1;
        if (push) exp_q.push_back({e, d});
        @(negedge SysClk);
        Read_Done = 1'b0;
    endtask

    task automatic wr_rd(input logic [7:0] wd, input logic push, input logic [7:0] ed);
        @(negedge SysClk);
        Data_In = wd; Rx_Error = '0; Data_Rdy = 1'b1; Read_Done = 1'b1;
        if (push) exp_q.push_back({3'b000, ed});
        @(negedge SysClk);
        Data_Rdy = 1'b0; Read_Done = 1'b0;
    endtask

    // Monitor: a pop is presented on the edge where Read_Done meets a non-empty FIFO
    initial begin
        forever begin
            @(posedge SysClk);
            if (Rst && Read_Done && !FIFO_Empty) begin
                @(negedge SysClk);
                if (exp_q.size() == 0) begin
                    total++;
                    $display("FAIL pop_unexpected: got 0x%0h expected no pop", Data_Out);
                end else begin
                    logic [10:0] x;
                    x = exp_q.pop_front();
                    chk("pop.data", 16'(Data_Out), 16'(x[7:0]));
                    chk("pop.err",  16'(Err_Out),  16'(x[10:8]));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        // 1. reset state
        repeat (2) @(negedge SysClk);
        chk_flags("reset", 1'b1, 1'b0, 1'b0);
        chk("reset.data", 16'(Data_Out), 16'h0);
        chk("reset.err",  16'(Err_Out),  16'h0);
        Rst = 1'b1;
        @(negedge SysClk);

        // read while empty: ignored
        rd(1'b0, 8'h00, 3'b000);
        chk("empty_rd.data", 16'(Data_Out), 16'h0);
        chk_flags("empty_rd", 1'b1, 1'b0, 1'b0);

        // 2. fill and drain in order
        for (int i = 0; i < 8; i++) wr(8'(i), 3'b000);
        chk_flags("fill8", 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 8; i++) begin
            rd(1'b1, 8'(i), 3'b000);
            if (i == 6) chk("drain7.empty", 16'(FIFO_Empty), 16'h0);
        end
        chk_flags("drain8", 1'b1, 1'b0, 1'b0);
        chk("drain8.hold", 16'(Data_Out), 16'h07);

        // 3. threshold
        for (int i = 0; i < 4; i++) begin
            wr(8'hA0 + 8'(i), 3'b000);
            if (i == 2) chk_flags("thr3", 1'b0, 1'b0, 1'b0);
        end
        chk_flags("thr4", 1'b0, 1'b1, 1'b0);
        rd(1'b1, 8'hA0, 3'b000);
        chk_flags("thr_rd", 1'b0, 1'b0, 1'b0);
        for (int i = 1; i < 4; i++) rd(1'b1, 8'hA0 + 8'(i), 3'b000);
        chk_flags("thr_drain", 1'b1, 1'b0, 1'b0);

        // simultaneous write+read on empty: only the write lands
        wr_rd(8'h77, 1'b0, 8'h00);
        chk("wr_rd_empty.hold", 16'(Data_Out), 16'hA3);
        chk_flags("wr_rd_empty", 1'b0, 1'b0, 1'b0);
        rd(1'b1, 8'h77, 3'b000);
        chk_flags("wr_rd_empty_drain", 1'b1, 1'b0, 1'b0);

        // 4. overflow
        for (int i = 0; i < 8; i++) wr(8'h10 + 8'(i), 3'b000);
        chk_flags("ovf_pre", 1'b0, 1'b1, 1'b0);
        wr(8'h18, 3'b000);
        chk_flags("ovf_post", 1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 8; i++) rd(1'b1, 8'h10 + 8'(i), 3'b000);
        chk_flags("ovf_drain", 1'b1, 1'b0, 1'b1);
        @(negedge SysClk);
        Rst = 1'b0;
        #1;
        chk_flags("ovf_rst", 1'b1, 1'b0, 1'b0);
        chk("ovf_rst.data", 16'(Data_Out), 16'h0);
        @(negedge SysClk);
        Rst = 1'b1;

        // 5. simultaneous write+read while full
        for (int i = 0; i < 8; i++) wr(8'h20 + 8'(i), 3'b000);
        wr_rd(8'h55, 1'b1, 8'h20);
        chk_flags("full_wr_rd", 1'b0, 1'b1, 1'b0);
        for (int i = 1; i < 8; i++) rd(1'b1, 8'h20 + 8'(i), 3'b000);
        chk("full_wr_rd.notempty", 16'(FIFO_Empty), 16'h0);
        rd(1'b1, 8'h55, 3'b000);
        chk_flags("full_wr_rd_drain", 1'b1, 1'b0, 1'b0);

        // 6. error tag
        wr(8'hAA, 3'b010);
`ifdef RX_FIFO_ERR_TAG_EN
        chk("tag.empty", 16'(FIFO_Empty), 16'h0);
        rd(1'b1, 8'hAA, 3'b010);
        wr(8'hBB, 3'b000);
        rd(1'b1, 8'hBB, 3'b000);
`else
        chk("tag.empty", 16'(FIFO_Empty), 16'h1);
        rd(1'b0, 8'h00, 3'b000);
        chk("tag.hold", 16'(Data_Out), 16'h55);
        // errored byte at full must not raise overflow
        for (int i = 0; i < 8; i++) wr(8'h30 + 8'(i), 3'b000);
        wr(8'hCC, 3'b100);
        chk_flags("tag_full", 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 8; i++) rd(1'b1, 8'h30 + 8'(i), 3'b000);
`endif
        chk_flags("final", 1'b1, 1'b0, 1'b0);

        repeat (3) @(negedge SysClk);
        chk("scoreboard.left", 16'(exp_q.size()), 16'h0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
